sound_arbiter: RTL and testbench
================================

# sound_arbiter

Shares the single tone generator of the foosball sound path among three requesters: end-of-game melody, goal jingle and kick click. Latches one-cycle requests, grants by fixed priority with preemption, and sequences each melody note by note from a constant melody ROM, timed by the system beat pulse. It drives `frequency`/`enable` directly into the tone generator and replaces per-melody hard-coded state chains.

## Interface
- `NUM_SRC`, 3: number of requesters; fixed; index 0 is highest priority.
- `clk`  in  1  system clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `beat`  in  1  one-cycle pulse from the game timer; unit of note duration.
- `req`  in  3  one-cycle request pulses: [0] end-of-game, [1] goal, [2] kick.
- `end_sel`  in  2  end-of-game melody: 0 victory, 1 loss, 2 draw, 3 treated as draw; sampled with `req[0]`.
- `frequency`  out  4  note code to the tone generator (0..11).
- `enable`  out  1  tone generator on.
- `grant`  out  3  one-hot source currently owning the generator; 0 when idle.
- `done`  out  1  one-cycle pulse when a melody finishes its last note (not on preemption).
- `locked`  out  1  end-of-game melody finished; block silent until reset.

## Operation
- Pending flags `pend[2:0]`: set on `req[i]`, cleared in the cycle source i is granted. Repeated requests while pending coalesce. A request from the playing source sets its flag again, so the melody replays after the current one finishes.
- `end_sel` is captured into `sel_q` in any cycle where `req[0]`=1.
- ROM entry format: {freq[3:0], dur[1:0], last}; the note lasts dur+1 beats.
- Melodies (freq/beats):
  - victory: 9,2,6,9,6,2, each 1 beat.
  - loss: 5,6,7, each 2 beats.
  - draw: 0,5,10,0, each 1 beat.
  - goal: 7,11,7, each 1 beat.
  - kick: 11, 1 beat.
- FSM states: IDLE, LOAD, PLAY, LOCKED.
  - IDLE: `enable`=0 and `grant`=0. If any `pend` is set, pick the lowest set index, set `addr` to that melody's start, then go to LOAD.
  - LOAD: one cycle. Register the ROM entry into freq/dur/last, clear the beat counter, then go to PLAY.
  - PLAY: `enable`=1 and `frequency`=registered freq. Count beats. On the (dur+1)th beat:
    - if not last, `addr`+1 and go to LOAD;
    - if last and source 0, pulse `done` and go to LOCKED;
    - otherwise pulse `done` and go to IDLE.
  - Preemption: in LOAD or PLAY, if `pend[j]` is set with j < current source, the next state is LOAD of melody j. The current melody is dropped, is not resumed, and does not raise `done`.
  - LOCKED: `enable`=0, `locked`=1, all requests ignored and flags cleared. Left only by reset.
- Simultaneous requests: the highest priority wins. Others stay pending and are served in priority order afterwards.

## Timing
- Reset values: state IDLE, `pend`=0, `frequency`=0, `enable`=0, `grant`=0, `done`=0, `locked`=0, `sel_q`=0.
- Latency: `req` at cycle n → `pend` set at n+1 → LOAD at n+1 (if IDLE) → `enable`=1 and `frequency` valid at n+2.
- Between consecutive notes `enable` stays high. During the LOAD cycle `frequency` holds the previous note. This one-cycle glitch is acceptable.
- Beat counting: a `beat` in the LOAD cycle is not counted. A `beat` in any PLAY cycle counts, including the first.
- All outputs are registered. `done` is high for exactly one cycle, the cycle after the final counted beat.
- Reset mid-melody: outputs go to reset values immediately (async); pending requests are lost.

## Structure
- Package `sound_pkg`:
  - state enum;
  - source index constants;
  - note-entry struct;
  - melody start addresses (victory 0, loss 6, draw 9, goal 13, kick 16);
  - 32-entry ROM constant.
- Sub-module `melody_rom`: combinational lookup from 5-bit `addr` to entry, registered in LOAD.

## Test plan
- `req[2]` alone: `frequency`=11, `enable`=1 from n+2 until 1 beat counted; `done` pulse; back to IDLE with `grant`=0.
- `req[1]`, then `req[2]` mid-note: goal plays 7,11,7 uninterrupted, `done`; then kick plays 11 for one beat, second `done`.
- Kick playing, `req[1]` arrives: kick is dropped with no `done`; `grant`=010 two cycles later; goal plays in full.
- `req[0]` with `end_sel`=1: loss notes 5,6,7 each span 2 beats; `done`, then `locked`=1. A later `req[1]` gives `enable`=0 and `grant`=0.
- `req`=111 in one cycle, `end_sel`=0: victory plays 9,2,6,9,6,2, then LOCKED. Goal and kick never play.
- Reset asserted mid-victory: all outputs 0 immediately. After release, `req[2]` plays kick normally.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types, source indices and the melody ROM contents for the foosball
// sound arbiter.
package sound_pkg;

    localparam int NUM_SRC = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_LOCKED
    } state_t;

    localparam logic [1:0] SRC_END  = 2'd0;
    localparam logic [1:0] SRC_GOAL = 2'd1;
    localparam logic [1:0] SRC_KICK = 2'd2;

    typedef struct packed {
        logic [3:0] freq;
        logic [1:0] dur;
        logic       last;
    } note_t;

    localparam logic [4:0] ADDR_VICTORY = 5'd0;
    localparam logic [4:0] ADDR_LOSS    = 5'd6;
    localparam logic [4:0] ADDR_DRAW    = 5'd9;
    localparam logic [4:0] ADDR_GOAL    = 5'd13;
    localparam logic [4:0] ADDR_KICK    = 5'd16;

    function automatic note_t mk_note(input logic [3:0] f, input logic [1:0] d, input logic l);
        note_t n;
        n.freq = f;
        n.dur  = d;
        n.last = l;
        return n;
    endfunction

    localparam note_t NOTE_NONE = '0;

    // dur is beats-1; last marks the final note of each melody
    localparam note_t MELODY_ROM [32] = '{
        mk_note(4'd9, 2'd0, 1'b0), mk_note(4'd2, 2'd0, 1'b0), mk_note(4'd6, 2'd0, 1'b0),
        mk_note(4'd9, 2'd0, 1'b0), mk_note(4'd6, 2'd0, 1'b0), mk_note(4'd2, 2'd0, 1'b1),
        mk_note(4'd5, 2'd1, 1'b0), mk_note(4'd6, 2'd1, 1'b0), mk_note(4'd7, 2'd1, 1'b1),
        mk_note(4'd0, 2'd0, 1'b0), mk_note(4'd5, 2'd0, 1'b0), mk_note(4'd10, 2'd0, 1'b0),
        mk_note(4'd0, 2'd0, 1'b1),
        mk_note(4'd7, 2'd0, 1'b0), mk_note(4'd11, 2'd0, 1'b0), mk_note(4'd7, 2'd0, 1'b1),
        mk_note(4'd11, 2'd0, 1'b1),
        NOTE_NONE, NOTE_NONE, NOTE_NONE, NOTE_NONE, NOTE_NONE,
        NOTE_NONE, NOTE_NONE, NOTE_NONE, NOTE_NONE, NOTE_NONE,
        NOTE_NONE, NOTE_NONE, NOTE_NONE, NOTE_NONE, NOTE_NONE
    };

    function automatic logic [1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    function automatic logic [4:0] start_addr(input logic [1:0] src, input logic [1:0] sel);
        case (src)
            SRC_GOAL: return ADDR_GOAL;
            SRC_KICK: return ADDR_KICK;
            default: begin
                case (sel)
                    2'd0:    return ADDR_VICTORY;
                    2'd1:    return ADDR_LOSS;
                    default: return ADDR_DRAW;
                endcase
            end
        endcase
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Constant melody table; combinational lookup, sampled by the arbiter in LOAD.
module melody_rom
    import sound_pkg::*;
(
    input  logic [4:0] addr,
    output note_t      entry
);

    assign entry = MELODY_ROM[addr];

endmodule

// File: rtl/sound_arbiter.sv
// Fixed-priority, preemptive arbiter that plays one ROM melody at a time on
// the shared tone generator, stepping notes on the game beat pulse.
module sound_arbiter
    import sound_pkg::*;
(
    input  logic         clk,
    input  logic         resetN,
    input  logic         beat,
    input  logic [2:0]   req,
    input  logic [1:0]   end_sel,
    output logic [3:0]   frequency,
    output logic         enable,
    output logic [2:0]   grant,
    output logic         done,
    output logic         locked
);

    state_t             state_reg, state_next;
    logic [NUM_SRC-1:0] pend_reg, pend_next;
    logic [1:0]         sel_reg, sel_next;
    logic [1:0]         cur_reg, cur_next;
    logic [4:0]         addr_reg, addr_next;
    logic [1:0]         dur_reg, dur_next;
    logic               last_reg, last_next;
    logic [1:0]         cnt_reg, cnt_next;
    logic [3:0]         frequency_reg, frequency_next;
    logic               enable_reg, enable_next;
    logic [2:0]         grant_reg, grant_next;
    logic               done_reg, done_next;
    logic               locked_reg, locked_next;

    note_t              rom_entry;
    logic [NUM_SRC-1:0] eff;
    logic [NUM_SRC-1:0] higher;
    logic [NUM_SRC-1:0] hi;
    logic [1:0]         sel_eff;

    melody_rom u_rom (
        .addr  (addr_reg),
        .entry (rom_entry)
    );

    // A fresh request is visible to arbitration in the same cycle it arrives
    assign eff     = pend_reg | req;
    assign sel_eff = req[0] ? end_sel : sel_reg;
    assign hi      = eff & higher;

    always_comb begin
        case (cur_reg)
            2'd0:    higher = 3'b000;
            2'd1:    higher = 3'b001;
            default: higher = 3'b011;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        pend_next      = eff;
        sel_next       = sel_eff;
        cur_next       = cur_reg;
        addr_next      = addr_reg;
        dur_next       = dur_reg;
        last_next      = last_reg;
        cnt_next       = cnt_reg;
        frequency_next = frequency_reg;
        done_next      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (|eff) begin
                    cur_next            = lowest_idx(eff);
                    addr_next           = start_addr(lowest_idx(eff), sel_eff);
                    pend_next[cur_next] = 1'b0;
                    state_next          = S_LOAD;
                end
            end
            S_LOAD: begin
                frequency_next = rom_entry.freq;
                dur_next       = rom_entry.dur;
                last_next      = rom_entry.last;
                cnt_next       = 2'd0;
                state_next     = S_PLAY;
            end
            S_PLAY: begin
                if (beat) begin
                    if (cnt_reg == dur_reg) begin
                        if (!last_reg) begin
                            addr_next  = addr_reg + 5'd1;
                            state_next = S_LOAD;
                        end else begin
                            done_next  = 1'b1;
                            state_next = (cur_reg == SRC_END) ? S_LOCKED : S_IDLE;
                        end
                    end else begin
                        cnt_next = cnt_reg + 2'd1;
                    end
                end
            end
            default: begin
                pend_next = '0;
            end
        endcase

        // A higher-priority pending source drops the current melody silently
        if ((state_reg == S_LOAD || state_reg == S_PLAY) && |hi) begin
            cur_next            = lowest_idx(hi);
            addr_next           = start_addr(lowest_idx(hi), sel_eff);
            pend_next[cur_next] = 1'b0;
            frequency_next      = frequency_reg;
            done_next           = 1'b0;
            state_next          = S_LOAD;
        end
    end

    always_comb begin
        enable_next = (state_next == S_PLAY) || (state_next == S_LOAD && enable_reg);
        grant_next  = '0;
        if ((state_reg == S_LOAD || state_reg == S_PLAY) &&
            (state_next == S_LOAD || state_next == S_PLAY))
            grant_next = 3'b001 << cur_reg;
        locked_next = (state_next == S_LOCKED);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg     <= S_IDLE;
            pend_reg      <= '0;
            sel_reg       <= '0;
            cur_reg       <= '0;
            addr_reg      <= '0;
            dur_reg       <= '0;
            last_reg      <= 1'b0;
            cnt_reg       <= '0;
            frequency_reg <= '0;
            enable_reg    <= 1'b0;
            grant_reg     <= '0;
            done_reg      <= 1'b0;
            locked_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pend_reg      <= pend_next;
            sel_reg       <= sel_next;
            cur_reg       <= cur_next;
            addr_reg      <= addr_next;
            dur_reg       <= dur_next;
            last_reg      <= last_next;
            cnt_reg       <= cnt_next;
            frequency_reg <= frequency_next;
            enable_reg    <= enable_next;
            grant_reg     <= grant_next;
            done_reg      <= done_next;
            locked_reg    <= locked_next;
        end
    end

    assign frequency = frequency_reg;
    assign enable    = enable_reg;
    assign grant     = grant_reg;
    assign done      = done_reg;
    assign locked    = locked_reg;

endmodule

// File: tb/tb_sound_arbiter.sv
// Directed bench for sound_arbiter: each melody is stepped beat by beat and
// every note, handover, done pulse and lock is compared to hand-derived values.
module tb_sound_arbiter;

    logic       clk;
    logic       resetN;
    logic       beat;
    logic [2:0] req;
    logic [1:0] end_sel;
    logic [3:0] frequency;
    logic       enable;
    logic [2:0] grant;
    logic       done;
    logic       locked;

    int n_checks = 0;
    int n_fail   = 0;

    int kick_f[8]    = '{11, 0, 0, 0, 0, 0, 0, 0};
    int goal_f[8]    = '{7, 11, 7, 0, 0, 0, 0, 0};
    int loss_f[8]    = '{5, 6, 7, 0, 0, 0, 0, 0};
    int victory_f[8] = '{9, 2, 6, 9, 6, 2, 0, 0};
    int draw_f[8]    = '{0, 5, 10, 0, 0, 0, 0, 0};

    sound_arbiter dut (
        .clk       (clk),
        .resetN    (resetN),
        .beat      (beat),
        .req       (req),
        .end_sel   (end_sel),
        .frequency (frequency),
        .enable    (enable),
        .grant     (grant),
        .done      (done),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag, input logic lk);
        check({tag, ".enable"}, enable, 1'b0);
        check({tag, ".grant"},  grant,  3'b000);
        check({tag, ".done"},   done,   1'b0);
        check({tag, ".locked"}, locked, lk);
    endtask

    task automatic pulse_req(input logic [2:0] r, input logic [1:0] sel);
        req     = r;
        end_sel = sel;
        step();
        req     = 3'b000;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        #2;
        resetN = 1'b1;
        step();
    endtask

    // Entered on the first PLAY cycle of the melody's first note.
    task automatic play_melody(input string tag, input logic [2:0] g, input int freqs[8],
                               input int n, input int beats, input logic lk);
        for (int i = 0; i < n; i++) begin
            string t;
            t = $sformatf("%s.n%0d", tag, i);
            $display("%s: note %0d freq=%0d grant=%b", tag, i, frequency, grant);
            check({t, ".freq"},   frequency, freqs[i][3:0]);
            check({t, ".enable"}, enable,    1'b1);
            check({t, ".grant"},  grant,     g);
            check({t, ".done"},   done,      1'b0);
            for (int b = 1; b <= beats; b++) begin
                beat = 1'b1;
                step();
                beat = 1'b0;
                if (b < beats) begin
                    check({t, ".hold_freq"},   frequency, freqs[i][3:0]);
                    check({t, ".hold_enable"}, enable,    1'b1);
                    step();
                end
            end
            if (i < n - 1) begin
                check({t, ".load_enable"}, enable,    1'b1);
                check({t, ".load_freq"},   frequency, freqs[i][3:0]);
                check({t, ".load_done"},   done,      1'b0);
                step();
            end else begin
                check({t, ".done"},      done,   1'b1);
                check({t, ".end_enable"}, enable, 1'b0);
                check({t, ".end_grant"},  grant,  3'b000);
                check({t, ".end_locked"}, locked, lk);
                step();
                check({t, ".done_once"}, done, 1'b0);
            end
        end
    endtask

    initial begin
        resetN  = 1'b0;
        beat    = 1'b0;
        req     = 3'b000;
        end_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.freq", frequency, 4'd0);
        check_quiet("reset", 1'b0);
        resetN = 1'b1;
        step();

        // Kick alone; a beat during LOAD must not be counted
        $display("test kick alone");
        pulse_req(3'b100, 2'd0);
        check("kick.load_enable", enable, 1'b0);
        check("kick.load_grant",  grant,  3'b000);
        beat = 1'b1;
        step();
        beat = 1'b0;
        play_melody("kick", 3'b100, kick_f, 1, 1, 1'b0);
        check_quiet("kick.idle", 1'b0);

        // Goal, kick requested mid-note: kick waits for goal to finish
        $display("test goal then kick");
        pulse_req(3'b010, 2'd0);
        step();
        pulse_req(3'b100, 2'd0);
        check("goalkick.no_preempt_freq", frequency, 4'd7);
        play_melody("goal1", 3'b010, goal_f, 3, 1, 1'b0);
        check("goalkick.load_enable", enable, 1'b0);
        step();
        play_melody("kick2", 3'b100, kick_f, 1, 1, 1'b0);

        // Kick preempted by goal: no done, grant switches two cycles later
        $display("test kick preempted by goal");
        pulse_req(3'b100, 2'd0);
        step();
        check("preempt.kick_freq", frequency, 4'd11);
        pulse_req(3'b010, 2'd0);
        check("preempt.grant_m1",  grant,  3'b100);
        check("preempt.done_m1",   done,   1'b0);
        check("preempt.enable_m1", enable, 1'b1);
        step();
        play_melody("goal2", 3'b010, goal_f, 3, 1, 1'b0);
        step();
        check_quiet("preempt.no_replay", 1'b0);

        // Loss melody (end_sel=1), 2 beats per note, then locked
        $display("test loss then locked");
        pulse_req(3'b001, 2'd1);
        end_sel = 2'd0;
        step();
        play_melody("loss", 3'b001, loss_f, 3, 2, 1'b1);
        pulse_req(3'b010, 2'd0);
        step();
        check_quiet("loss.locked_a", 1'b1);
        step();
        check_quiet("loss.locked_b", 1'b1);

        // All three requests at once: victory wins, others never play
        $display("test simultaneous requests");
        do_reset();
        check("sim.unlocked", locked, 1'b0);
        pulse_req(3'b111, 2'd0);
        step();
        play_melody("victory", 3'b001, victory_f, 6, 1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check_quiet($sformatf("sim.after%0d", k), 1'b1);
            step();
        end

        // Draw selected by end_sel=3
        $display("test end_sel=3 draw");
        do_reset();
        pulse_req(3'b001, 2'd3);
        step();
        play_melody("draw", 3'b001, draw_f, 4, 1, 1'b1);

        // Asynchronous reset in the middle of victory
        $display("test reset mid-melody");
        do_reset();
        pulse_req(3'b001, 2'd0);
        step();
        check("midrst.freq0", frequency, 4'd9);
        beat = 1'b1;
        step();
        beat = 1'b0;
        step();
        check("midrst.freq1", frequency, 4'd2);
        #2;
        resetN = 1'b0;
        #1;
        check("midrst.freq", frequency, 4'd0);
        check_quiet("midrst", 1'b0);
        step();
        #2;
        resetN = 1'b1;
        step();
        check_quiet("midrst.post", 1'b0);
        pulse_req(3'b100, 2'd0);
        step();
        play_melody("kick3", 3'b100, kick_f, 1, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
